// File: rtl/lcb_distributor_if.sv
// Signal bundle between the two LCB receivers, the shared Orbita frame-buffer port
// and the arbitration status. The distributor takes the slave view; requesters and memory take the master view.
interface lcb_distributor_if #(
    parameter int DROP_W = 8
);
    logic              busy_1;
    logic              busy_2;
    logic [11:0]       wrdOut_1;
    logic [11:0]       wrdOut_2;
    logic [9:0]        wrdAddr_1;
    logic [9:0]        wrdAddr_2;
    logic              wren_1;
    logic              wren_2;
    logic [9:0]        oldWrdAddr_1;
    logic [9:0]        oldWrdAddr_2;
    logic              oldRdEn_1;
    logic              oldRdEn_2;
    logic [11:0]       oldWrd_1;
    logic [11:0]       oldWrd_2;
    logic [11:0]       commWrdOut;
    logic [9:0]        commWrdAddr;
    logic              commWren;
    logic [9:0]        commOldWrdAddr;
    logic              commOldRdEn;
    logic [11:0]       commOldWrd;
    logic [1:0]        grant;
    logic [DROP_W-1:0] drop_1;
    logic [DROP_W-1:0] drop_2;

    modport master (
        output busy_1, busy_2, wrdOut_1, wrdOut_2, wrdAddr_1, wrdAddr_2,
        output wren_1, wren_2, oldWrdAddr_1, oldWrdAddr_2, oldRdEn_1, oldRdEn_2,
        output commOldWrd,
        input  oldWrd_1, oldWrd_2, commWrdOut, commWrdAddr, commWren,
        input  commOldWrdAddr, commOldRdEn, grant, drop_1, drop_2
    );

    modport slave (
        input  busy_1, busy_2, wrdOut_1, wrdOut_2, wrdAddr_1, wrdAddr_2,
        input  wren_1, wren_2, oldWrdAddr_1, oldWrdAddr_2, oldRdEn_1, oldRdEn_2,
        input  commOldWrd,
        output oldWrd_1, oldWrd_2, commWrdOut, commWrdAddr, commWren,
        output commOldWrdAddr, commOldRdEn, grant, drop_1, drop_2
    );
endinterface

// File: rtl/lcb_distributor.sv
// Round-robin arbiter sharing one Orbita frame-buffer port between two LCB receivers,
// routing pipelined read data back to the requester that issued each read.
module lcb_distributor #(
    parameter int RD_LAT = 2,
    parameter int DROP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    lcb_distributor_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN1  = 2'd1,
        ST_OWN2  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [1:0]        DRAIN_LOAD = 2'(RD_LAT);
    localparam logic [DROP_W-1:0] DROP_MAX   = {DROP_W{1'b1}};

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] cnt,
                                                  input logic              hit);
        logic [DROP_W-1:0] res;
        if (hit && (cnt != DROP_MAX)) begin
            res = cnt + DROP_W'(1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    state_e            state_q;
    logic              last2_q;      // 1: requester 2 was served last
    logic [1:0]        drain_cnt_q;
    logic [1:0]        grant_q;

    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_vld_d;
    logic [RD_LAT-1:0] tag_req2_q;
    logic [RD_LAT-1:0] tag_req2_d;
    logic [11:0]       old1_q;
    logic [11:0]       old1_d;
    logic [11:0]       old2_q;
    logic [11:0]       old2_d;
    logic [DROP_W-1:0] drop_1_q;
    logic [DROP_W-1:0] drop_1_d;
    logic [DROP_W-1:0] drop_2_q;
    logic [DROP_W-1:0] drop_2_d;

    logic              rej_1_s;
    logic              rej_2_s;
    logic [11:0]       comm_wrd_s;
    logic [9:0]        comm_wrd_addr_s;
    logic              comm_wren_s;
    logic [9:0]        comm_rd_addr_s;
    logic              comm_rd_en_s;

    // Arbitration FSM; grant is registered alongside the state so it never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last2_q     <= 1'b1;
            drain_cnt_q <= 2'd0;
            grant_q     <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.busy_1 && (!bus.busy_2 || last2_q)) begin
                        state_q <= ST_OWN1;
                        grant_q <= 2'b01;
                    end else if (bus.busy_2) begin
                        state_q <= ST_OWN2;
                        grant_q <= 2'b10;
                    end else begin
                        state_q <= ST_IDLE;
                        grant_q <= 2'b00;
                    end
                end
                ST_OWN1: begin
                    if (bus.busy_1) begin
                        state_q <= ST_OWN1;
                        grant_q <= 2'b01;
                    end else begin
                        state_q     <= ST_DRAIN;
                        grant_q     <= 2'b00;
                        last2_q     <= 1'b0;
                        drain_cnt_q <= DRAIN_LOAD;
                    end
                end
                ST_OWN2: begin
                    if (bus.busy_2) begin
                        state_q <= ST_OWN2;
                        grant_q <= 2'b10;
                    end else begin
                        state_q     <= ST_DRAIN;
                        grant_q     <= 2'b00;
                        last2_q     <= 1'b1;
                        drain_cnt_q <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    grant_q <= 2'b00;
                    if (drain_cnt_q <= 2'd1) begin
                        state_q     <= ST_IDLE;
                        drain_cnt_q <= 2'd0;
                    end else begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= drain_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    grant_q     <= 2'b00;
                    drain_cnt_q <= 2'd0;
                end
            endcase
        end
    end

    // Shared port follows the owner's inputs; zero whenever nobody owns it.
    always_comb begin
        comm_wrd_s      = 12'd0;
        comm_wrd_addr_s = 10'd0;
        comm_wren_s     = 1'b0;
        comm_rd_addr_s  = 10'd0;
        comm_rd_en_s    = 1'b0;
        case (state_q)
            ST_OWN1: begin
                comm_wrd_s      = bus.wrdOut_1;
                comm_wrd_addr_s = bus.wrdAddr_1;
                comm_wren_s     = bus.wren_1;
                comm_rd_addr_s  = bus.oldWrdAddr_1;
                comm_rd_en_s    = bus.oldRdEn_1;
            end
            ST_OWN2: begin
                comm_wrd_s      = bus.wrdOut_2;
                comm_wrd_addr_s = bus.wrdAddr_2;
                comm_wren_s     = bus.wren_2;
                comm_rd_addr_s  = bus.oldWrdAddr_2;
                comm_rd_en_s    = bus.oldRdEn_2;
            end
            default: begin
                comm_wren_s  = 1'b0;
                comm_rd_en_s = 1'b0;
            end
        endcase
    end

    // Read-tag pipeline, return-data steering and drop accounting.
    always_comb begin
        tag_vld_d  = tag_vld_q;
        tag_req2_d = tag_req2_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_req2_d[i] = tag_req2_q[i-1];
        end
        tag_vld_d[0]  = comm_rd_en_s;
        tag_req2_d[0] = (state_q == ST_OWN2);

        old1_d = old1_q;
        old2_d = old2_q;
        if (tag_vld_q[RD_LAT-1]) begin
            if (tag_req2_q[RD_LAT-1]) begin
                old2_d = bus.commOldWrd;
            end else begin
                old1_d = bus.commOldWrd;
            end
        end else begin
            old1_d = old1_q;
            old2_d = old2_q;
        end

        rej_1_s  = (bus.wren_1 | bus.oldRdEn_1) & ~grant_q[0];
        rej_2_s  = (bus.wren_2 | bus.oldRdEn_2) & ~grant_q[1];
        drop_1_d = sat_inc(drop_1_q, rej_1_s);
        drop_2_d = sat_inc(drop_2_q, rej_2_s);
    end

    // Datapath registers; reset also discards any reads still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q  <= '0;
            tag_req2_q <= '0;
            old1_q     <= 12'd0;
            old2_q     <= 12'd0;
            drop_1_q   <= '0;
            drop_2_q   <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_req2_q <= tag_req2_d;
            old1_q     <= old1_d;
            old2_q     <= old2_d;
            drop_1_q   <= drop_1_d;
            drop_2_q   <= drop_2_d;
        end
    end

    assign bus.grant          = grant_q;
    assign bus.oldWrd_1       = old1_q;
    assign bus.oldWrd_2       = old2_q;
    assign bus.drop_1         = drop_1_q;
    assign bus.drop_2         = drop_2_q;
    assign bus.commWrdOut     = comm_wrd_s;
    assign bus.commWrdAddr    = comm_wrd_addr_s;
    assign bus.commWren       = comm_wren_s;
    assign bus.commOldWrdAddr = comm_rd_addr_s;
    assign bus.commOldRdEn    = comm_rd_en_s;

endmodule

// File: tb/tb_lcb_distributor.sv
// Self-checking bench for lcb_distributor: directed arbitration sequences plus a
// read-return scoreboard fed by a fixed-latency memory model.
module tb_lcb_distributor;
    localparam int RD_LAT = 2;
    localparam int DROP_W = 8;

    typedef struct {
        int          due;
        logic        req2;
        logic [11:0] data;
    } sb_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          n_chk;
    int          n_pass;
    logic [11:0] exp_old1;
    logic [11:0] exp_old2;
    sb_t         sb_q[$];
    logic [9:0]  mem_pipe [RD_LAT];

    lcb_distributor_if #(.DROP_W(DROP_W)) bus ();

    lcb_distributor #(.RD_LAT(RD_LAT), .DROP_W(DROP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [11:0] mem_data(input logic [9:0] a);
        logic [11:0] d;
        if (a == 10'h3FF) d = 12'h5A5;
        else              d = {2'b10, a} ^ 12'h3C3;
        return d;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-buffer model: data for an address appears RD_LAT cycles after the request.
    always @(posedge clk) begin
        mem_pipe[0] <= bus.commOldWrdAddr;
        for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign bus.commOldWrd = mem_data(mem_pipe[RD_LAT-1]);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: retire due reads, then compare both return registers every cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            if (sb_q[0].req2) exp_old2 = sb_q[0].data;
            else              exp_old1 = sb_q[0].data;
            void'(sb_q.pop_front());
        end
        check_val("oldWrd_1", 32'(bus.oldWrd_1), 32'(exp_old1));
        check_val("oldWrd_2", 32'(bus.oldWrd_2), 32'(exp_old2));
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.busy_1 = 1'b0;       bus.busy_2 = 1'b0;
        bus.wrdOut_1 = 12'd0;    bus.wrdOut_2 = 12'd0;
        bus.wrdAddr_1 = 10'd0;   bus.wrdAddr_2 = 10'd0;
        bus.wren_1 = 1'b0;       bus.wren_2 = 1'b0;
        bus.oldWrdAddr_1 = 10'd0; bus.oldWrdAddr_2 = 10'd0;
        bus.oldRdEn_1 = 1'b0;    bus.oldRdEn_2 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        sb_q.delete();
        exp_old1 = 12'd0;
        exp_old2 = 12'd0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic issue_read(input logic req2, input logic [9:0] addr);
        sb_t e;
        if (req2) begin
            bus.oldRdEn_2 = 1'b1; bus.oldWrdAddr_2 = addr;
        end else begin
            bus.oldRdEn_1 = 1'b1; bus.oldWrdAddr_1 = addr;
        end
        e.due  = cyc + RD_LAT + 1;
        e.req2 = req2;
        e.data = mem_data(addr);
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        exp_old1 = 12'd0; exp_old2 = 12'd0;
        rst_n = 1'b0;
        clear_inputs();
        // Requests during reset must be ignored entirely.
        bus.busy_1 = 1'b1; bus.wren_1 = 1'b1; bus.oldRdEn_2 = 1'b1; bus.wrdOut_1 = 12'hFFF;
        step(2);
        check_val("rst_grant", 32'(bus.grant), 32'd0);
        check_val("rst_wren", 32'(bus.commWren), 32'd0);
        check_val("rst_rden", 32'(bus.commOldRdEn), 32'd0);
        check_val("rst_wrd", 32'(bus.commWrdOut), 32'd0);
        check_val("rst_drop1", 32'(bus.drop_1), 32'd0);
        check_val("rst_drop2", 32'(bus.drop_2), 32'd0);
        clear_inputs();
        rst_n = 1'b1;
        step();

        // Single requester write.
        bus.busy_1 = 1'b1;
        step();
        check_val("own1_grant", 32'(bus.grant), 32'h1);
        bus.wren_1 = 1'b1; bus.wrdAddr_1 = 10'h155; bus.wrdOut_1 = 12'hABC;
        #1;
        check_val("own1_wren", 32'(bus.commWren), 32'd1);
        check_val("own1_waddr", 32'(bus.commWrdAddr), 32'h155);
        check_val("own1_wdata", 32'(bus.commWrdOut), 32'hABC);
        step();
        check_val("own1_drop1", 32'(bus.drop_1), 32'd0);
        check_val("own1_drop2", 32'(bus.drop_2), 32'd0);
        bus.wren_1 = 1'b0;
        issue_read(1'b0, 10'h0F0);
        step();
        bus.busy_1 = 1'b0;
        issue_read(1'b0, 10'h123);
        #1;
        check_val("last_own1_rden", 32'(bus.commOldRdEn), 32'd1);
        check_val("last_own1_raddr", 32'(bus.commOldWrdAddr), 32'h123);
        step();
        bus.oldRdEn_1 = 1'b0;
        bus.wren_1 = 1'b1;
        #1;
        check_val("drain1_grant", 32'(bus.grant), 32'd0);
        check_val("drain_blocked", 32'(bus.commWren), 32'd0);
        step();
        bus.wren_1 = 1'b0;
        check_val("drain2_grant", 32'(bus.grant), 32'd0);
        check_val("drain_drop1", 32'(bus.drop_1), 32'd1);
        step(3);

        // Round robin on simultaneous requests.
        do_reset();
        bus.busy_1 = 1'b1; bus.busy_2 = 1'b1;
        step();
        check_val("tie1_grant", 32'(bus.grant), 32'h1);
        bus.busy_1 = 1'b0;
        step();
        check_val("rr_drain1", 32'(bus.grant), 32'd0);
        step();
        check_val("rr_drain2", 32'(bus.grant), 32'd0);
        step();
        check_val("rr_idle", 32'(bus.grant), 32'd0);
        step();
        check_val("rr_own2", 32'(bus.grant), 32'h2);
        bus.busy_1 = 1'b1;
        issue_read(1'b1, 10'h3FF);
        #1;
        check_val("own2_rden", 32'(bus.commOldRdEn), 32'd1);
        check_val("own2_raddr", 32'(bus.commOldWrdAddr), 32'h3FF);
        step();
        bus.oldRdEn_2 = 1'b0;
        step(3);
        check_val("busy_no_drop", 32'(bus.drop_1), 32'd0);
        bus.busy_2 = 1'b0;
        step();
        bus.busy_2 = 1'b1;
        step(2);
        check_val("tie2_idle", 32'(bus.grant), 32'd0);
        step();
        check_val("tie2_grant", 32'(bus.grant), 32'h1);

        // Rejected writes from requester 2 while requester 1 owns the port.
        bus.wren_2 = 1'b1; bus.wrdAddr_2 = 10'h2AA; bus.wrdOut_2 = 12'h777;
        for (int i = 0; i < 300; i++) begin
            bus.wren_1 = (i % 3 == 0);
            #1;
            check_val("wren_follow", 32'(bus.commWren), 32'(bus.wren_1));
            check_val("drop2_count", 32'(bus.drop_2), (i > 255) ? 32'd255 : 32'(i));
            step();
        end
        check_val("drop2_sat", 32'(bus.drop_2), 32'd255);
        check_val("drop1_clean", 32'(bus.drop_1), 32'd0);
        bus.wren_2 = 1'b0; bus.wren_1 = 1'b0;

        // Reset abort while requester 2 has reads in flight.
        bus.busy_1 = 1'b0; bus.busy_2 = 1'b1;
        step(4);
        check_val("abort_own2", 32'(bus.grant), 32'h2);
        issue_read(1'b1, 10'h0AA);
        step();
        issue_read(1'b1, 10'h0BB);
        step();
        bus.oldRdEn_2 = 1'b0;
        rst_n = 1'b0;
        sb_q.delete();
        exp_old1 = 12'd0;
        exp_old2 = 12'd0;
        bus.busy_2 = 1'b0;
        #1;
        check_val("abort_grant", 32'(bus.grant), 32'd0);
        check_val("abort_drop2", 32'(bus.drop_2), 32'd0);
        check_val("abort_old2", 32'(bus.oldWrd_2), 32'd0);
        check_val("abort_rden", 32'(bus.commOldRdEn), 32'd0);
        step();
        rst_n = 1'b1;
        step(5);
        check_val("post_abort_old2", 32'(bus.oldWrd_2), 32'd0);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lcb_distributor.md
LCB_DISTRIBUTOR -- requirements
Module: lcb_distributor

Interface
REQ-001 Parameter RD_LAT, default 2: read latency in clk cycles from commOldRdEn/commOldWrdAddr to valid commOldWrd; legal range 1..3.
REQ-002 Parameter DROP_W, default 8: width of each drop counter.
REQ-003 clk  input  1  system clock, 80 MHz domain; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 busy_1, busy_2  input  1 each  requester k (LCB receiver) wants the shared memory port.
REQ-006 wrdOut_k  input  12  write data; wrdAddr_k  input  10  write address; wren_k  input  1  write enable (k=1,2).
REQ-007 oldWrdAddr_k  input  10  read address; oldRdEn_k  input  1  read enable; oldWrd_k  output  12  returned read data (k=1,2).
REQ-008 commWrdOut  output  12; commWrdAddr  output  10; commWren  output  1: shared write port toward the Orbita frame buffers.
REQ-009 commOldWrdAddr  output  10; commOldRdEn  output  1: shared read request; commOldWrd  input  12: shared read data.
REQ-010 grant  output  2  one-hot owner: 01 = requester 1, 10 = requester 2, 00 = none.
REQ-011 drop_1, drop_2  output  DROP_W  saturating counts of rejected accesses.

Function
REQ-012 The FSM SHALL have states IDLE, OWN1, OWN2 and DRAIN; a last-served register holds 1 or 2.
REQ-013 From IDLE, busy_1 alone SHALL go to OWN1 and busy_2 alone to OWN2, both on the next edge.
REQ-014 From IDLE with busy_1 and busy_2 both high, the FSM SHALL grant the requester that is not last-served (round robin).
REQ-015 OWNk SHALL persist while busy_k is high; no preemption, regardless of the other busy.
REQ-016 When busy_k is low in OWNk, the FSM SHALL set last-served=k and enter DRAIN with a drain counter loaded to RD_LAT.
REQ-017 DRAIN SHALL last exactly RD_LAT cycles and then go to IDLE; no grant is issued directly from DRAIN.
REQ-018 Idle-to-regrant is therefore RD_LAT+1 cycles minimum.
REQ-019 grant SHALL be 01 in OWN1, 10 in OWN2, and 00 in IDLE and DRAIN.
REQ-020 In OWNk, all comm* outputs SHALL combinationally follow requester k's inputs; in all other states they SHALL be 0.
REQ-021 A read-tag shift register, RD_LAT deep, SHALL record the requester index for every cycle in which commOldRdEn=1.
REQ-022 When a tag emerges from the shift register, the matching oldWrd_k SHALL register commOldWrd, so oldWrd_k is valid RD_LAT+1 cycles after the request.
REQ-023 oldWrd_k SHALL hold its last value otherwise; the non-matching requester's oldWrd SHALL be unchanged.
REQ-024 In-flight reads issued in the last OWNk cycle SHALL be delivered to requester k during DRAIN.
REQ-025 wren_k or oldRdEn_k asserted while grant≠k SHALL increment drop_k by 1 (once per cycle if both are asserted), saturating at all-ones.
REQ-026 A rejected access SHALL NOT reach the comm* port.
REQ-027 The same-cycle busy_k rise of a requester not yet granted SHALL NOT count as a drop unless wren_k or oldRdEn_k is also asserted.

Reset
REQ-028 While reset=0: state=IDLE, last-served=2 (so requester 1 wins the first tie), drain counter=0, tag register cleared.
REQ-029 While reset=0: oldWrd_1=oldWrd_2=0, drop_1=drop_2=0, grant=00, all comm* outputs=0.
REQ-030 Reset asserted mid-ownership or mid-drain SHALL abort immediately and discard pending read tags.
REQ-031 Operation resumes on the first clk edge after reset deasserts.

Verification
REQ-032 busy_1=1 only, wren_1=1, wrdAddr_1=0x155, wrdOut_1=0xABC -> grant=01 next cycle; commWren=1, commWrdAddr=0x155, commWrdOut=0xABC; drop counters 0.
REQ-033 busy_1 and busy_2 rise together after reset -> OWN1. After busy_1 falls: DRAIN for 2 cycles, IDLE, then OWN2. On the next simultaneous tie -> OWN1.
REQ-034 In OWN2, oldRdEn_2=1 with addr 0x3FF; memory model returns 0x5A5 after 2 cycles -> oldWrd_2=0x5A5 at cycle 3; oldWrd_1 unchanged.
REQ-035 Read issued in the final OWN1 cycle -> data delivered to oldWrd_1 during DRAIN; grant=00 throughout DRAIN.
REQ-036 In OWN1, wren_2 held high for 300 cycles -> drop_2 saturates at 255; commWren reflects only wren_1.
REQ-037 reset pulsed low in OWN2 with reads in flight -> grant=00 and drop/oldWrd outputs=0 immediately; no oldWrd update after release.
